// File: rtl/urish_sram_pkg.sv
// ============================================================================
// urish_sram_pkg : shared widths, BIST states and test patterns
// Rev 1.0
// ============================================================================
`default_nettype none

package urish_sram_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] PAT_A = 8'h55;
  localparam logic [DATA_W-1:0] PAT_B = 8'hAA;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W1   = 3'd1,
    R1   = 3'd2,
    W2   = 3'd3,
    R2   = 3'd4,
    DONE = 3'd5
  } bist_state_e;

endpackage

`default_nettype wire

// File: rtl/urish_sram_array.sv
// ============================================================================
// urish_sram_array : flop-based storage, one sync write port, write-first read
// Rev 1.0
// ============================================================================
`default_nettype none

module urish_sram_array
  import urish_sram_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately left unreset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read and write share one address, so any write is a same-address write.
  assign rdata_o = we_i ? wdata_i : mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/urish_sram_test.sv
// ============================================================================
// urish_sram_test : pin-driven 64x8 SRAM exerciser; optional self-test
//                   compiled in with SRAM_TEST_BIST_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module urish_sram_test
  import urish_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_en;
  logic              user_we;

  assign user_we = ena & ui_in[6];
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  urish_sram_array u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rdata_en) begin
      rdata_q <= arr_rdata;
    end
  end

`ifdef SRAM_TEST_BIST_EN
  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [3:0]        fail_q, fail_d;
  logic              sel_q;
  logic              busy, done, start, last;
  logic [DATA_W-1:0] pat, expect_w;

  assign busy  = (state_q == W1) || (state_q == R1) || (state_q == W2) || (state_q == R2);
  assign done  = (state_q == DONE);
  assign start = ena && ui_in[7] && !sel_q && ((state_q == IDLE) || (state_q == DONE));
  assign last  = (baddr_q == {ADDR_W{1'b1}});
  assign pat   = ((state_q == W1) || (state_q == R1)) ? PAT_A : PAT_B;
  assign expect_w = {{(DATA_W-ADDR_W){1'b0}}, baddr_q} ^ pat;

  // While busy the BIST owns the array and the user read register is frozen.
  assign arr_addr  = busy ? baddr_q : ui_in[ADDR_W-1:0];
  assign arr_we    = busy ? (ena && ((state_q == W1) || (state_q == W2))) : user_we;
  assign arr_wdata = busy ? expect_w : uio_in;
  assign rdata_en  = ena && !busy;
  assign uo_out    = ui_in[7] ? {busy, done, (fail_q == 4'd0), 1'b0, fail_q} : rdata_q;

  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    fail_d  = fail_q;
    if (ena) begin
      if (start) begin
        state_d = W1;
        baddr_d = '0;
        fail_d  = '0;
      end else if (busy) begin
        baddr_d = baddr_q + 1'b1;
        if (((state_q == R1) || (state_q == R2)) && (arr_rdata != expect_w) && (fail_q != 4'hF)) begin
          fail_d = fail_q + 4'd1;
        end
        if (last) begin
          unique case (state_q)
            W1:      state_d = R1;
            R1:      state_d = W2;
            W2:      state_d = R2;
            default: state_d = DONE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baddr_q <= '0;
      fail_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      fail_q  <= fail_d;
      if (ena) begin
        sel_q <= ui_in[7];
      end
    end
  end
`else
  logic unused_sel;

  assign unused_sel = ui_in[7];
  assign arr_addr   = ui_in[ADDR_W-1:0];
  assign arr_we     = user_we;
  assign arr_wdata  = uio_in;
  assign rdata_en   = ena;
  assign uo_out     = rdata_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_urish_sram_test.sv
// ============================================================================
// tb_urish_sram_test : directed self-checking bench for urish_sram_test
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_urish_sram_test;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  urish_sram_test dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic we, input logic [5:0] addr, input logic [7:0] data);
    ui_in  = {sel, we, addr};
    uio_in = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo_out got %h exp %h", uo_out, 8'h00);
    end
    checks++;
    if (uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio_oe got %h exp %h", uio_oe, 8'h00);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio_out got %h exp %h", uio_out, 8'h00);
    end
    #2;
    rst_n  = 1'b1;
    #2;
    clk_en = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 6'd3, 8'hA5);
    cyc();
    drive(1'b0, 1'b1, 6'd63, 8'h3C);
    cyc();
    drive(1'b0, 1'b0, 6'd3, 8'h00);
    checks++;
    if (uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL wr_latency_pre got %h exp %h", uo_out, 8'h3C);
    end
    cyc();
    checks++;
    if (uo_out !== 8'hA5) begin
      errors++;
      $display("FAIL rd_addr3 got %h exp %h", uo_out, 8'hA5);
    end
    drive(1'b0, 1'b0, 6'd63, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL rd_addr63 got %h exp %h", uo_out, 8'h3C);
    end
  endtask

  task automatic test_ena_low();
    ena = 1'b0;
    drive(1'b0, 1'b1, 6'd3, 8'hFF);
    cyc();
    cyc();
    checks++;
    if (uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL ena_low_hold got %h exp %h", uo_out, 8'h3C);
    end
    ena = 1'b1;
    drive(1'b0, 1'b0, 6'd3, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'hA5) begin
      errors++;
      $display("FAIL ena_low_nowrite got %h exp %h", uo_out, 8'hA5);
    end
  endtask

  task automatic test_write_first();
    drive(1'b0, 1'b1, 6'd10, 8'h77);
    cyc();
    checks++;
    if (uo_out !== 8'h77) begin
      errors++;
      $display("FAIL write_first got %h exp %h", uo_out, 8'h77);
    end
    drive(1'b0, 1'b0, 6'd3, 8'h00);
    cyc();
    drive(1'b0, 1'b0, 6'd10, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'h77) begin
      errors++;
      $display("FAIL write_first_stored got %h exp %h", uo_out, 8'h77);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_v;
    for (int a = 0; a < 64; a++) begin
      exp_v = 8'(a) ^ 8'h5A;
      drive(1'b0, 1'b1, 6'(a), exp_v);
      cyc();
    end
    for (int a = 0; a < 64; a++) begin
      exp_v = 8'(a) ^ 8'h5A;
      drive(1'b0, 1'b0, 6'(a), 8'h00);
      cyc();
      checks++;
      if (uo_out !== exp_v) begin
        errors++;
        $display("FAIL sweep_addr%0d got %h exp %h", a, uo_out, exp_v);
      end
    end
  endtask

`ifdef SRAM_TEST_BIST_EN
  task automatic test_bist();
    int n;
    drive(1'b1, 1'b0, 6'd0, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'hA0) begin
      errors++;
      $display("FAIL bist_busy_status got %h exp %h", uo_out, 8'hA0);
    end
    // A user write attempted while busy must be dropped.
    drive(1'b1, 1'b1, 6'd5, 8'h00);
    n = 1;
    while (uo_out[7] === 1'b1 && n < 400) begin
      cyc();
      if (uo_out[7] === 1'b1) n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL bist_busy_cycles got %0d exp %0d", n, 256);
    end
    drive(1'b1, 1'b0, 6'd5, 8'h00);
    cyc();
    cyc();
    checks++;
    if (uo_out !== 8'h60) begin
      errors++;
      $display("FAIL bist_done_status got %h exp %h", uo_out, 8'h60);
    end
    drive(1'b0, 1'b0, 6'd5, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'hAF) begin
      errors++;
      $display("FAIL bist_mem5 got %h exp %h", uo_out, 8'hAF);
    end
    drive(1'b0, 1'b0, 6'd63, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'h95) begin
      errors++;
      $display("FAIL bist_mem63 got %h exp %h", uo_out, 8'h95);
    end
  endtask
`else
  task automatic test_sel_ignored();
    drive(1'b1, 1'b0, 6'd10, 8'h00);
    cyc();
    checks++;
    if (uo_out !== 8'h50) begin
      errors++;
      $display("FAIL sel_ignored got %h exp %h", uo_out, 8'h50);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #3;
    test_reset();
    test_write_read();
    test_ena_low();
    test_write_first();
    test_sweep();
`ifdef SRAM_TEST_BIST_EN
    test_bist();
`else
    test_sel_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
